// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point add/sub front end.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned MAX_FP_W  = 64;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    // Canonical quiet NaN: sign 0, exponent all-ones, fraction MSB set.
    // Returned at the widest supported size; callers truncate to their width.
    function automatic logic [MAX_FP_W-1:0] canon_qnan(input int unsigned exp_w,
                                                       input int unsigned man_w);
        logic [MAX_FP_W-1:0] v;
        v = ((MAX_FP_W'(1) << exp_w) - MAX_FP_W'(1)) << man_w;
        v = v | (MAX_FP_W'(1) << (man_w - 1));
        return v;
    endfunction

    // Classify an operand from width-independent field summaries.
    function automatic fp_class_e fp_classify(input logic exp_ones,
                                              input logic exp_zero,
                                              input logic frac_nz,
                                              input logic frac_msb);
        fp_class_e c;
        if (exp_ones) begin
            if (!frac_nz)      c = INF;
            else if (frac_msb) c = QNAN;
            else               c = SNAN;
        end else if (exp_zero) begin
            c = frac_nz ? SUB : ZERO;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Right shift with sticky OR of all shifted-out bits into bit 0; saturates at d >= W.
module fp_rshift_sticky #(
    parameter int unsigned W    = 27,
    parameter int unsigned SH_W = 8
) (
    input  logic [W-1:0]    src,
    input  logic [SH_W-1:0] sh_amt,
    output logic [W-1:0]    res_c
);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         sticky;

    // Shift, collect lost bits, fold them into the LSB.
    always_comb begin
        shifted   = '0;
        lost_mask = '0;
        sticky    = 1'b0;
        res_c     = '0;
        if (32'(sh_amt) >= 32'(W)) begin
            sticky = |src;
            res_c  = {{(W-1){1'b0}}, sticky};
        end else begin
            shifted   = src >> sh_amt;
            lost_mask = ~({W{1'b1}} << sh_amt);
            sticky    = |(src & lost_mask);
            res_c     = {shifted[W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage unpack/order/align front end for FP add/sub with valid/ready flow control.
module fp_align_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF,
    parameter int unsigned TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sub,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W-1:0]         exp_l,
    output logic [MAN_W+3:0]         mant_l,
    output logic [MAN_W+3:0]         mant_s,
    output logic                     sign_l,
    output logic                     eff_sub,
    output logic                     special,
    output logic [EXP_W+MAN_W:0]     special_val,
    output logic                     nv,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned FP_W = EXP_W + MAN_W + 1;
    localparam int unsigned MT_W = MAN_W + 4;
    localparam logic [FP_W-1:0] QNAN_VAL = FP_W'(canon_qnan(EXP_W, MAN_W));

    // Flow control
    logic v1;
    logic ready2;
    logic load1;
    logic load2;

    assign ready2   = !out_valid || out_ready;
    assign in_ready = !v1 || ready2;
    assign load1    = in_valid && in_ready;
    assign load2    = v1 && ready2;

    // Stage 1 combinational decode
    logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b, c_exp_l, c_exp_s, c_d;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic [MAN_W:0]   sig_a, sig_b, c_sig_l, c_sig_s;
    logic             sign_a, sign_b, swap, c_sign_l, c_eff_sub, c_special, c_nv;
    logic             nan_a, nan_b, inf_a, inf_b;
    logic [FP_W-1:0]  c_special_val;
    fp_class_e        cls_a, cls_b;

    // Unpack, classify, order by magnitude and decode specials.
    always_comb begin
        exp_a  = a[FP_W-2 -: EXP_W];
        exp_b  = b[FP_W-2 -: EXP_W];
        frac_a = a[MAN_W-1:0];
        frac_b = b[MAN_W-1:0];
        sign_a = a[FP_W-1];
        sign_b = b[FP_W-1] ^ sub;
        cls_a  = fp_classify(&exp_a, ~|exp_a, |frac_a, frac_a[MAN_W-1]);
        cls_b  = fp_classify(&exp_b, ~|exp_b, |frac_b, frac_b[MAN_W-1]);
        eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
        eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
        sig_a  = {|exp_a, frac_a};
        sig_b  = {|exp_b, frac_b};
        swap   = b[FP_W-2:0] > a[FP_W-2:0];

        c_exp_l   = swap ? eexp_b : eexp_a;
        c_exp_s   = swap ? eexp_a : eexp_b;
        c_sig_l   = swap ? sig_b  : sig_a;
        c_sig_s   = swap ? sig_a  : sig_b;
        c_sign_l  = swap ? sign_b : sign_a;
        c_d       = c_exp_l - c_exp_s;
        c_eff_sub = sign_a ^ sign_b;

        nan_a = (cls_a == QNAN) || (cls_a == SNAN);
        nan_b = (cls_b == QNAN) || (cls_b == SNAN);
        inf_a = (cls_a == INF);
        inf_b = (cls_b == INF);

        c_special     = 1'b0;
        c_special_val = '0;
        c_nv          = 1'b0;
        if (nan_a || nan_b) begin
            c_special     = 1'b1;
            c_special_val = QNAN_VAL;
            c_nv          = (cls_a == SNAN) || (cls_b == SNAN);
        end else if (inf_a && inf_b && c_eff_sub) begin
            c_special     = 1'b1;
            c_special_val = QNAN_VAL;
            c_nv          = 1'b1;
        end else if (inf_a) begin
            c_special     = 1'b1;
            c_special_val = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (inf_b) begin
            c_special     = 1'b1;
            c_special_val = {sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Stage 1 registers
    logic [EXP_W-1:0] s1_exp_l, s1_d;
    logic [MAN_W:0]   s1_sig_l, s1_sig_s;
    logic             s1_sign_l, s1_eff_sub, s1_special, s1_nv;
    logic [FP_W-1:0]  s1_special_val;
    logic [TAG_W-1:0] s1_tag;

    // Valid bits for both stages; reset drops in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load1)      v1 <= 1'b1;
            else if (load2) v1 <= 1'b0;
            if (ready2)     out_valid <= v1;
        end
    end

    // Stage 1 data capture on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exp_l       <= '0;
            s1_d           <= '0;
            s1_sig_l       <= '0;
            s1_sig_s       <= '0;
            s1_sign_l      <= 1'b0;
            s1_eff_sub     <= 1'b0;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
            s1_nv          <= 1'b0;
            s1_tag         <= '0;
        end else if (load1) begin
            s1_exp_l       <= c_exp_l;
            s1_d           <= c_d;
            s1_sig_l       <= c_sig_l;
            s1_sig_s       <= c_sig_s;
            s1_sign_l      <= c_sign_l;
            s1_eff_sub     <= c_eff_sub;
            s1_special     <= c_special;
            s1_special_val <= c_special_val;
            s1_nv          <= c_nv;
            s1_tag         <= in_tag;
        end
    end

    // Stage 2 alignment
    logic [MT_W-1:0] aligned;

    fp_rshift_sticky #(
        .W    (MT_W),
        .SH_W (EXP_W)
    ) u_align (
        .src    ({s1_sig_s, 3'b000}),
        .sh_amt (s1_d),
        .res_c  (aligned)
    );

    // Stage 2 output registers, loaded on hand-off from stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_l       <= '0;
            mant_l      <= '0;
            mant_s      <= '0;
            sign_l      <= 1'b0;
            eff_sub     <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
            nv          <= 1'b0;
            out_tag     <= '0;
        end else if (load2) begin
            exp_l       <= s1_exp_l;
            mant_l      <= {s1_sig_l, 3'b000};
            mant_s      <= aligned;
            sign_l      <= s1_sign_l;
            eff_sub     <= s1_eff_sub;
            special     <= s1_special;
            special_val <= s1_special_val;
            nv          <= s1_nv;
            out_tag     <= s1_tag;
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe (single precision configuration).
module tb_fp_align_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_l;
    logic [26:0] mant_l;
    logic [26:0] mant_s;
    logic        sign_l;
    logic        eff_sub;
    logic        special;
    logic [31:0] special_val;
    logic        nv;
    logic [4:0]  out_tag;

    fp_align_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sub         (sub),
        .a           (a),
        .b           (b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .exp_l       (exp_l),
        .mant_l      (mant_l),
        .mant_s      (mant_s),
        .sign_l      (sign_l),
        .eff_sub     (eff_sub),
        .special     (special),
        .special_val (special_val),
        .nv          (nv),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
        else              n_pass++;
    endtask

    typedef struct packed {
        logic [7:0]  exp_l;
        logic [26:0] mant_l;
        logic [26:0] mant_s;
        logic        sign_l;
        logic        eff_sub;
        logic        special;
        logic [31:0] sv;
        logic        nv;
        logic [4:0]  tag;
    } result_t;

    result_t q[$];

    // Reference: real-number view of the spec rules using plain integer arithmetic.
    function automatic result_t model(input logic [31:0] oa, input logic [31:0] ob,
                                      input logic os, input logic [4:0] ot);
        result_t r;
        longint ea, eb, fa, fb, el, es, src_l, src_s, d, sh, rem, ms;
        bit sa, sb, swap, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
        ea = longint'(oa[30:23]);
        eb = longint'(ob[30:23]);
        fa = longint'(oa[22:0]);
        fb = longint'(ob[22:0]);
        sa = oa[31];
        sb = ob[31] ^ os;
        swap = (eb * 8388608 + fb) > (ea * 8388608 + fa);
        if (swap) begin
            el = (eb == 0) ? 1 : eb; es = (ea == 0) ? 1 : ea;
            src_l = ((eb != 0 ? 8388608 : 0) + fb) * 8;
            src_s = ((ea != 0 ? 8388608 : 0) + fa) * 8;
            r.sign_l = sb;
        end else begin
            el = (ea == 0) ? 1 : ea; es = (eb == 0) ? 1 : eb;
            src_l = ((ea != 0 ? 8388608 : 0) + fa) * 8;
            src_s = ((eb != 0 ? 8388608 : 0) + fb) * 8;
            r.sign_l = sa;
        end
        d = el - es;
        if (d >= 27) begin
            ms = (src_s != 0) ? 1 : 0;
        end else begin
            sh  = src_s / (longint'(1) << d);
            rem = src_s - sh * (longint'(1) << d);
            ms  = sh;
            if (rem != 0) ms = ms | 1;
        end
        r.exp_l   = 8'(el);
        r.mant_l  = 27'(src_l);
        r.mant_s  = 27'(ms);
        r.eff_sub = sa ^ sb;
        r.tag     = ot;
        nan_a  = (ea == 255) && (fa != 0);
        nan_b  = (eb == 255) && (fb != 0);
        snan_a = nan_a && (fa < 4194304);
        snan_b = nan_b && (fb < 4194304);
        inf_a  = (ea == 255) && (fa == 0);
        inf_b  = (eb == 255) && (fb == 0);
        r.special = 1'b0; r.sv = 32'h0; r.nv = 1'b0;
        if (nan_a || nan_b) begin
            r.special = 1'b1; r.sv = 32'h7FC00000; r.nv = snan_a || snan_b;
        end else if (inf_a && inf_b && (sa != sb)) begin
            r.special = 1'b1; r.sv = 32'h7FC00000; r.nv = 1'b1;
        end else if (inf_a) begin
            r.special = 1'b1; r.sv = {sa, 31'h7F800000};
        end else if (inf_b) begin
            r.special = 1'b1; r.sv = {sb, 31'h7F800000};
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        int unsigned sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 9);
        f   = 23'($urandom);
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       begin e = 8'hFF; f = 23'h0; end
            3:       e = 8'(120 + $urandom_range(0, 15));
            default: e = 8'($urandom_range(1, 254));
        endcase
        if ($urandom_range(0, 7) == 0) f = 23'h0;
        return {1'($urandom), e, f};
    endfunction

    task automatic compare_out(input result_t x, input string pfx);
        check({pfx, "_exp_l"},   64'(exp_l),   64'(x.exp_l));
        check({pfx, "_mant_l"},  64'(mant_l),  64'(x.mant_l));
        check({pfx, "_mant_s"},  64'(mant_s),  64'(x.mant_s));
        check({pfx, "_sign_l"},  64'(sign_l),  64'(x.sign_l));
        check({pfx, "_eff_sub"}, 64'(eff_sub), 64'(x.eff_sub));
        check({pfx, "_special"}, 64'(special), 64'(x.special));
        check({pfx, "_nv"},      64'(nv),      64'(x.nv));
        check({pfx, "_tag"},     64'(out_tag), 64'(x.tag));
        if (x.special) check({pfx, "_special_val"}, 64'(special_val), 64'(x.sv));
    endtask

    // One operation through an empty pipe with out_ready=1; expectations from hand calculation.
    task automatic dir_case(input string nm, input logic [31:0] ia, input logic [31:0] ib,
                            input logic isub, input result_t x);
        @(negedge clk);
        a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1; in_tag = x.tag;
        #1 check({nm, "_in_ready"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({nm, "_lat1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        #1 check({nm, "_lat2"}, 64'(out_valid), 64'(1));
        compare_out(x, nm);
        check({nm, "_model"}, 64'(model(ia, ib, isub, x.tag) == x), 64'(1));
    endtask

    function automatic result_t mk(input logic [7:0] e, input logic [26:0] ml, input logic [26:0] ms,
                                   input logic sl, input logic es, input logic sp,
                                   input logic [31:0] sv, input logic n, input logic [4:0] t);
        result_t r;
        r.exp_l = e; r.mant_l = ml; r.mant_s = ms; r.sign_l = sl; r.eff_sub = es;
        r.special = sp; r.sv = sp ? sv : 32'h0; r.nv = n; r.tag = t;
        return r;
    endfunction

    int exp_tag;
    int next_tag;
    int budget;
    result_t got_front;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        a = '0; b = '0; in_tag = '0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_mant_s",    64'(mant_s),    64'(0));
        check("rst_exp_l",     64'(exp_l),     64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        dir_case("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0,
                 mk(8'd127, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd1));
        dir_case("one_minus_half", 32'h3F800000, 32'h3F000000, 1'b1,
                 mk(8'd127, 27'h4000000, 27'h2000000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd2));
        dir_case("swap", 32'h3F800000, 32'h40000000, 1'b0,
                 mk(8'd128, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd3));
        dir_case("d24_sticky", 32'h4B800000, 32'h3F800001, 1'b0,
                 mk(8'd151, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd4));
        dir_case("saturate", 32'h7F000000, 32'h00000001, 1'b0,
                 mk(8'd254, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd5));
        dir_case("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1,
                 mk(8'd255, 27'h4000000, 27'h4000000, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 1'b1, 5'd6));
        dir_case("snan", 32'h7FA00000, 32'h00000000, 1'b0,
                 mk(8'd255, 27'h5000000, 27'h0000000, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 1'b1, 5'd7));
        dir_case("neg_inf", 32'hFF800000, 32'h3F800000, 1'b0,
                 mk(8'd255, 27'h4000000, 27'h0000001, 1'b1, 1'b1, 1'b1, 32'hFF800000, 1'b0, 5'd8));

        // Backpressure: 4 tags, out_ready low for the first 3 cycles
        @(negedge clk);
        exp_tag = 1; next_tag = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (next_tag <= 4);
            in_tag    = 5'(next_tag);
            a = rand_op(); b = rand_op(); sub = 1'($urandom);
            #1;
            if (cyc == 2) begin
                check("bp_in_ready_full", 64'(in_ready),  64'(0));
                check("bp_hold_valid",    64'(out_valid), 64'(1));
                check("bp_hold_tag",      64'(out_tag),   64'(1));
            end
            if (out_valid && out_ready) begin
                check("bp_order", 64'(out_tag), 64'(exp_tag));
                exp_tag++;
            end
            if (in_valid && in_ready) next_tag++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_all_out", 64'(exp_tag), 64'(5));

        // Mid-stream reset: two tags in flight, then reset
        out_ready = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            in_valid = 1'b1; in_tag = 5'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1 check("rst_pre_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid",    64'(out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready),  64'(1));
        check("rst_mid_tag",      64'(out_tag),   64'(0));
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_tag = 5'd17;
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        budget = 0;
        #1;
        while (!out_valid && budget < 10) begin
            @(negedge clk); #1; budget++;
        end
        check("rst_no_stale_tag", 64'(out_tag), 64'(17));
        check("rst_recover_lat", 64'(budget), 64'(1));
        @(negedge clk);
        #1 check("rst_drained", 64'(out_valid), 64'(0));

        // Randomised traffic against the reference model
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a = rand_op();
            b = ($urandom_range(0, 3) == 0) ? a ^ 32'(1 << $urandom_range(0, 31)) : rand_op();
            sub = 1'($urandom);
            in_tag = 5'($urandom);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rnd_unexpected_out", 64'(1), 64'(0));
                else begin
                    got_front = q.pop_front();
                    compare_out(got_front, "rnd");
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, sub, in_tag));
        end

        // Drain remaining results with a bounded wait
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            #1;
            if (out_valid) begin
                got_front = q.pop_front();
                compare_out(got_front, "drain");
            end
            @(negedge clk);
            budget++;
        end
        check("drain_empty", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
